// File: rtl/apple1_ps2_pkg.sv
// Shared PS/2 definitions for the Apple-1 keyboard path.
// Used by the host transmitter and the ps2keyboard receiver.
package apple1_ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_REQ      = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_WAITIDLE = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } ps2_tx_state_e;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-FF synchronizer, then a level that only moves when three
// consecutive synchronized samples agree, with single-cycle edge strobes.
module ps2_line_filter (
    input  logic sys_clock,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic fall,
    output logic rise
);
    logic [1:0] sync;
    logic [1:0] hist;
    logic [2:0] win;

    assign win = {hist, sync[1]};

    // Idle bus is high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            sync  <= 2'b11;
            hist  <= 2'b11;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], line_in};
            hist <= {hist[0], sync[1]};
            if (win == 3'b000)
                level <= 1'b0;
            else if (win == 3'b111)
                level <= 1'b1;
        end
    end

    assign fall = level && (win == 3'b000);
    assign rise = !level && (win == 3'b111);

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send,
// device-clocked shifting of data + odd parity, stop release and ACK check.
module ps2_host_tx
    import apple1_ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES    = 2500,
    parameter int FIRST_CLK_TIMEOUT = 375000,
    parameter int BIT_TIMEOUT       = 50000
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       rx_inhibit,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam int MAX_A   = (INHIBIT_CYCLES > FIRST_CLK_TIMEOUT) ? INHIBIT_CYCLES : FIRST_CLK_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > BIT_TIMEOUT) ? MAX_A : BIT_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    ps2_tx_state_e state;
    logic [CW-1:0] cnt;
    logic [3:0]    bitcnt;
    logic [3:0]    bit_next;
    logic [8:0]    shreg;
    logic          dat_drv;
    logic          cnt_expired;

    logic clk_level, clk_fall, clk_rise;
    logic dat_level, dat_fall, dat_rise;
    logic unused_strobes;

    ps2_line_filter u_clk_filt (
        .sys_clock (sys_clock),
        .reset     (reset),
        .line_in   (ps2_clk),
        .level     (clk_level),
        .fall      (clk_fall),
        .rise      (clk_rise)
    );

    ps2_line_filter u_dat_filt (
        .sys_clock (sys_clock),
        .reset     (reset),
        .line_in   (ps2_din),
        .level     (dat_level),
        .fall      (dat_fall),
        .rise      (dat_rise)
    );

    assign unused_strobes = ^{clk_rise, dat_fall, dat_rise};

    assign bit_next    = (bitcnt == 4'(PS2_FRAME_BITS)) ? bitcnt : bitcnt + 4'd1;
    // Checking for 1 rather than 0 makes the hold exactly the loaded count.
    assign cnt_expired = (cnt <= CW'(1));

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            dat_drv <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        shreg <= {odd_parity(tx_data), tx_data};
                        cnt   <= CW'(INHIBIT_CYCLES);
                        state <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt_expired) begin
                        cnt   <= '0;
                        state <= ST_REQ;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_REQ: begin
                    cnt     <= CW'(FIRST_CLK_TIMEOUT);
                    bitcnt  <= '0;
                    dat_drv <= 1'b1;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (clk_fall) begin
                        bitcnt <= bit_next;
                        cnt    <= CW'(BIT_TIMEOUT);
                        // Falls 1-9 present data LSB first then parity.
                        if (bit_next <= 4'd9) begin
                            dat_drv <= ~shreg[0];
                            shreg   <= {1'b0, shreg[8:1]};
                        end else if (bit_next == 4'd10) begin
                            dat_drv <= 1'b0;
                        end else begin
                            dat_drv <= 1'b0;
                            state   <= dat_level ? ST_ERR : ST_WAITIDLE;
                        end
                    end else if (cnt_expired) begin
                        dat_drv <= 1'b0;
                        state   <= ST_ERR;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAITIDLE: begin
                    if (clk_level && dat_level)
                        state <= ST_DONE;
                    else if (cnt_expired)
                        state <= ST_ERR;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_DONE, ST_ERR: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state == ST_INHIBIT) || (state == ST_REQ) ||
                        (state == ST_SHIFT)   || (state == ST_WAITIDLE);
    assign rx_inhibit = busy;
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERR);
    assign ps2_clk_oe = (state == ST_INHIBIT) || (state == ST_REQ);
    assign ps2_dat_oe = (state == ST_REQ) || ((state == ST_SHIFT) && dat_drv);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain keyboard model clocks frames out of the
// host, while a monitor pops expected outcomes on each done/error pulse.
module tb_ps2_host_tx;
    localparam int IC   = 20;
    localparam int FCT  = 300;
    localparam int BT   = 200;
    localparam int HALF = 40;

    logic       sys_clock = 1'b0;
    logic       reset     = 1'b1;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_start  = 1'b0;
    logic       busy, done, error, rx_inhibit, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1, dev_dat = 1'b1;
    logic       ps2_clk, ps2_din;

    assign ps2_clk = dev_clk & ~ps2_clk_oe;
    assign ps2_din = dev_dat & ~ps2_dat_oe;

    always #5 sys_clock = ~sys_clock;

    ps2_host_tx #(
        .INHIBIT_CYCLES    (IC),
        .FIRST_CLK_TIMEOUT (FCT),
        .BIT_TIMEOUT       (BT)
    ) dut (
        .sys_clock  (sys_clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .rx_inhibit (rx_inhibit),
        .ps2_clk    (ps2_clk),
        .ps2_din    (ps2_din),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    typedef struct packed { logic is_err; logic chk_frame; logic [10:0] frame; } exp_t;
    typedef struct packed { logic [7:0] nfalls; logic ack; } dev_cmd_t;

    exp_t        exp_q[$];
    logic [10:0] dev_q[$];
    dev_cmd_t    cmd_q[$];

    int n_checks = 0, n_fail = 0, n_done = 0, n_err = 0, dev_finished = 0;
    int hold_len = 0, req_len = 0, last_hold = 0, last_req = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest expectation.
    always @(negedge sys_clock) begin
        exp_t e;
        if (!reset && (done || error)) begin
            if (done)  n_done++;
            if (error) n_err++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'b0, done, error}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", {30'b0, done, error}, e.is_err ? 32'd1 : 32'd2);
                chk("released_at_pulse", {28'b0, busy, rx_inhibit, ps2_clk_oe, ps2_dat_oe}, 32'd0);
                if (e.chk_frame) begin
                    if (dev_q.size() == 0) chk("frame_captured", 32'd0, 32'd1);
                    else chk("frame_bits", {21'b0, dev_q.pop_front()}, {21'b0, e.frame});
                end
            end
        end
    end

    // Length of each clock-hold run and how many of its cycles also pull data.
    always @(negedge sys_clock) begin
        if (ps2_clk_oe) begin
            hold_len <= hold_len + 1;
            if (ps2_dat_oe) req_len <= req_len + 1;
        end else if (hold_len != 0) begin
            last_hold <= hold_len;
            last_req  <= req_len;
            hold_len  <= 0;
            req_len   <= 0;
        end
    end

    // Keyboard model: waits for request-to-send, clocks nfalls edges,
    // samples the host data at each rising edge, optionally ACKs.
    initial begin : device
        dev_cmd_t    c;
        logic [10:0] got;
        int          w;
        forever begin
            @(negedge sys_clock);
            if (cmd_q.size() != 0) begin
                c = cmd_q.pop_front();
                w = 0;
                while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 5000) begin
                    @(negedge sys_clock);
                    w++;
                end
                if (w >= 5000) begin
                    chk("dev_request_seen", {31'b0, ps2_dat_oe}, 32'd1);
                end else begin
                    repeat (10) @(negedge sys_clock);
                    got = '0;
                    got[0] = ps2_din;
                    for (int k = 1; k <= int'(c.nfalls); k++) begin
                        dev_clk = 1'b0;
                        repeat (HALF) @(negedge sys_clock);
                        if (k <= 10) got[k] = ps2_din;
                        dev_clk = 1'b1;
                        if (k == 10) dev_q.push_back(got);
                        if (k == 10 && c.ack) begin
                            repeat (HALF / 2) @(negedge sys_clock);
                            dev_dat = 1'b0;
                            repeat (HALF / 2) @(negedge sys_clock);
                        end else begin
                            repeat (HALF) @(negedge sys_clock);
                        end
                    end
                    dev_dat = 1'b1;
                end
                dev_finished++;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        @(posedge sys_clock); #1;
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge sys_clock); #1;
        tx_start = 1'b0;
    endtask

    task automatic wait_pulse(input string name, input int maxc);
        int w;
        w = 0;
        while (!(done || error) && w < maxc) begin
            @(negedge sys_clock);
            w++;
        end
        if (w >= maxc) chk(name, {31'b0, done || error}, 32'd1);
    endtask

    task automatic wait_dev(input int target);
        int w;
        w = 0;
        while (dev_finished < target && w < 5000) begin
            @(negedge sys_clock);
            w++;
        end
        if (w >= 5000) chk("dev_finished", dev_finished, target);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w, cyc;
        repeat (3) @(posedge sys_clock); #1;
        chk("reset_state", {26'b0, busy, done, error, rx_inhibit, ps2_clk_oe, ps2_dat_oe}, 32'd0);

        tx_data  = 8'hED;
        tx_start = 1'b1;
        @(posedge sys_clock); #1;
        chk("reset_beats_start", {30'b0, busy, ps2_clk_oe}, 32'd0);
        tx_start = 1'b0;
        reset    = 1'b0;
        repeat (10) @(posedge sys_clock);

        // 0xED: bits 1,0,1,1,0,1,1,1 then parity 1
        cmd_q.push_back('{nfalls: 8'd11, ack: 1'b1});
        exp_q.push_back('{is_err: 1'b0, chk_frame: 1'b1, frame: {1'b1, 1'b1, 8'hED, 1'b0}});
        send(8'hED);
        chk("start_latency", {29'b0, busy, ps2_clk_oe, rx_inhibit}, 32'd7);
        wait_pulse("ed_pulse", 3000);
        @(posedge sys_clock); #1;
        chk("ed_idle_after", {28'b0, ps2_clk_oe, ps2_dat_oe, busy, error}, 32'd0);
        wait_dev(1);

        // 0x01 (parity 0) then 0x00 (parity 1), second start right after done
        cmd_q.push_back('{nfalls: 8'd11, ack: 1'b1});
        cmd_q.push_back('{nfalls: 8'd11, ack: 1'b1});
        exp_q.push_back('{is_err: 1'b0, chk_frame: 1'b1, frame: {1'b1, 1'b0, 8'h01, 1'b0}});
        exp_q.push_back('{is_err: 1'b0, chk_frame: 1'b1, frame: {1'b1, 1'b1, 8'h00, 1'b0}});
        send(8'h01);
        wait_pulse("b2b_first", 3000);
        send(8'h00);
        chk("b2b_second_accepted", {31'b0, busy}, 32'd1);
        wait_pulse("b2b_second", 3000);
        wait_dev(3);

        // No ACK: 0x5A has four ones, parity 1
        cmd_q.push_back('{nfalls: 8'd11, ack: 1'b0});
        exp_q.push_back('{is_err: 1'b1, chk_frame: 1'b1, frame: {1'b1, 1'b1, 8'h5A, 1'b0}});
        send(8'h5A);
        wait_pulse("noack_pulse", 3000);
        wait_dev(4);

        // Inhibit length, and starts while busy must not disturb 0x3C
        cmd_q.push_back('{nfalls: 8'd11, ack: 1'b1});
        exp_q.push_back('{is_err: 1'b0, chk_frame: 1'b1, frame: {1'b1, 1'b1, 8'h3C, 1'b0}});
        send(8'h3C);
        repeat (5) @(posedge sys_clock); #1;
        tx_data = 8'h00; tx_start = 1'b1;
        @(posedge sys_clock); #1;
        tx_start = 1'b0;
        repeat (200) @(posedge sys_clock); #1;
        tx_data = 8'hFF; tx_start = 1'b1;
        @(posedge sys_clock); #1;
        tx_start = 1'b0;
        wait_pulse("busy_start_pulse", 3000);
        chk("inhibit_hold_cycles", last_hold, IC + 1);
        chk("req_data_low_cycles", last_req, 32'd1);
        wait_dev(5);

        // Silent device: error exactly FCT cycles after clock release
        exp_q.push_back('{is_err: 1'b1, chk_frame: 1'b0, frame: 11'd0});
        send(8'h12);
        w = 0;
        while (ps2_clk_oe && w < 200) begin @(negedge sys_clock); w++; end
        cyc = 0;
        while (!error && cyc < 1000) begin @(negedge sys_clock); cyc++; end
        chk("silent_timeout_cycles", cyc, FCT);

        // Reset after fall 4 of 0x00 (host is pulling data for bit 3)
        cmd_q.push_back('{nfalls: 8'd4, ack: 1'b0});
        send(8'h00);
        wait_dev(6);
        chk("abort_driving_bit3", {30'b0, busy, ps2_dat_oe}, 32'd3);
        @(posedge sys_clock); #1;
        reset = 1'b1;
        @(posedge sys_clock); #1;
        chk("reset_mid_frame_released", {27'b0, ps2_clk_oe, ps2_dat_oe, busy, done, error}, 32'd0);
        reset = 1'b0;
        repeat (10) @(posedge sys_clock);

        // Fresh 0xFF after the abort: parity 1
        cmd_q.push_back('{nfalls: 8'd11, ack: 1'b1});
        exp_q.push_back('{is_err: 1'b0, chk_frame: 1'b1, frame: {1'b1, 1'b1, 8'hFF, 1'b0}});
        send(8'hFF);
        wait_pulse("ff_pulse", 3000);
        wait_dev(7);
        repeat (20) @(posedge sys_clock); #1;

        chk("expectations_drained", exp_q.size(), 32'd0);
        chk("done_count", n_done, 32'd5);
        chk("error_count", n_err, 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
